uart_irq_ctrl: RTL
==================

Name: uart_irq_ctrl

Overview:
- Interrupt aggregation stage directly downstream of the CSR handshake block.
- Consumes the CSR block's three outputs:
  - W1C clear pulse vector, on ir_clear.
  - Held enable mask, on ir_en.
  - Held config word, on conf.
- Latches per-source UART event pulses into a pending register, coalesces enabled events, and drives one interrupt line to the host.
- Readback of the pending and overflow status goes to the register-read path.

Parameters:
- CONFIG_WIDTH, 32, width of the CSR words; must match the CSR block.
- NUM_SRC, 8, number of event sources; 1..16, and ≤ CONFIG_WIDTH/2.
- CNT_W, 8, width of the coalescing event counter.

Ports:
- clock  in  1  single clock domain.
- reset  in  1  asynchronous, active-low reset.
- evt_in  in  NUM_SRC  single-cycle event pulses from the UART (rx_valid, tx_done, overrun, frame_err, ...).
- ir_clear  in  CONFIG_WIDTH  one-cycle W1C mask; bit i clears source i.
- ir_en  in  CONFIG_WIDTH  level enable mask; bit i enables source i.
- conf  in  CONFIG_WIDTH  config word:
  - [0] global enable.
  - [1] pulse mode (0 = level irq, 1 = one-cycle irq).
  - [15:8] coalesce threshold; only the low CNT_W bits of this field are used; 0 is treated as 1.
  - [31:16] timeout in cycles; 0 disables the timeout.
- status_out  out  CONFIG_WIDTH  readback word:
  - [NUM_SRC-1:0] pending.
  - [16+NUM_SRC-1:16] overflow.
  - All other bits 0.
- irq_out  out  1  interrupt to host.
- irq_state  out  2  FSM state for debug.

Behaviour:
- Reset (reset=0, async): pending=0, overflow=0, cnt=0, timer=0, state=IDLE, irq_out=0, status_out=0. Outputs hold these values until the first clock edge after reset is released.
- pending[i]:
  - Set on the edge where evt_in[i]=1.
  - Cleared where ir_clear[i]=1 and evt_in[i]=0.
  - Simultaneous set and clear: set wins, so no event is lost.
  - pending updates regardless of the enable settings.
- overflow[i]:
  - Set when evt_in[i]=1 and pending[i]=1 and ir_clear[i]=0.
  - Cleared by ir_clear[i].
  - Sticky otherwise.
- Derived terms:
  - pnd_nxt = next value of pending.
  - masked = pnd_nxt & ir_en[NUM_SRC-1:0].
  - newev = |(evt_in & ir_en[NUM_SRC-1:0]).
  - thr = effective threshold: conf[15:8] truncated to CNT_W bits, with 0 → 1.
- FSM, all registered:
  - IDLE:
    - If conf[0] & |masked: load cnt=1, timer=0.
    - Go to FIRE if thr==1, else COLLECT.
  - COLLECT:
    - Each cycle: timer+1 (saturating); cnt+1 if newev (saturating at 2^CNT_W-1).
    - If |masked==0: go to IDLE, cnt=0.
    - Else go to FIRE when cnt_nxt>=thr, or when conf[31:16]!=0 and timer_nxt>=conf[31:16].
  - FIRE:
    - Level mode: stay while |masked; go to IDLE when masked==0.
    - Pulse mode: unconditionally go to HOLD next cycle.
  - HOLD (pulse mode only): go to IDLE when |masked==0.
- Global disable: conf[0]=0 forces IDLE from any state on the next edge, and clears cnt and timer. pending and overflow are kept.
- irq_out is registered and equals (state_nxt==FIRE):
  - Level mode: high for the whole FIRE residency.
  - Pulse mode: exactly one cycle per FIRE entry.
- Latency, with thr=1: evt_in sampled at edge k → pending and irq_out high after edge k, i.e. one clock.
- Clearing:
  - An ir_clear pulse that empties masked drops a level irq after the same edge.
  - An event arriving in the same cycle as its clear keeps irq high.
- Enable change: ir_en rising while pending is already set triggers from IDLE on the next edge, with no new event needed.
- status_out is registered and mirrors pending and overflow with the same timing as those registers.

Test Plan:
- Reset with conf=0x0000_0101, ir_en=0xFF. Pulse evt_in=0x01 at cycle 5 → status_out=0x0000_0001 and irq_out=1 from cycle 6. Pulse ir_clear=0x01 at cycle 10 → irq_out=0 and status_out=0 from cycle 11.
- Coalescing: conf=0x0000_0401, so thr=4. Send 4 events on source 2, 3 cycles apart → irq_out=1 exactly one cycle after the 4th event; irq_state=COLLECT before that.
- Timeout: conf=0x0014_0801, so thr=8, timeout=20. Single event at cycle 0 → irq_out rises at cycle 20, with timer saturation not reached.
- Pulse mode: conf=0x0000_0103 with one event → irq_out high for exactly 1 cycle. A second event on another source while in HOLD produces no new pulse until ir_clear empties masked and a fresh event arrives.
- Collision and overflow: evt_in[3] twice without clear → status_out bit 19 = 1. Then evt_in[3] and ir_clear[3] in the same cycle → pending[3]=1 and overflow[3]=0.
- Mid-operation async reset: assert reset=0 mid-COLLECT with pending=0x0F → irq_out=0, status_out=0 and state IDLE immediately, before any clock edge. After release, ir_en=0x00 with events → pending set and irq_out stays 0.

Source files
------------

// File: rtl/uart_irq_ctrl.sv
// rtl/uart_irq_ctrl.sv - UART event latching, coalescing and interrupt generation
module uart_irq_ctrl #(
    parameter int CONFIG_WIDTH = 32,
    parameter int NUM_SRC      = 8,
    parameter int CNT_W        = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_SRC-1:0]      evt_in,
    input  logic [CONFIG_WIDTH-1:0] ir_clear,
    input  logic [CONFIG_WIDTH-1:0] ir_en,
    input  logic [CONFIG_WIDTH-1:0] conf,
    output logic [CONFIG_WIDTH-1:0] status_out,
    output logic                    irq_out,
    output logic [1:0]              irq_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FIRE    = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_SRC-1:0]      pending_q, pending_d;
    logic [NUM_SRC-1:0]      overflow_q, overflow_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [15:0]             timer_q, timer_d;
    logic                    irq_q, irq_d;
    logic [CONFIG_WIDTH-1:0] status_q, status_d;

    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] en;
    logic [NUM_SRC-1:0] masked;
    logic               any_masked;
    logic               newev;
    logic               glb_en;
    logic               pulse_mode;
    logic [7:0]         thr_field;
    logic [CNT_W-1:0]   thr;
    logic [15:0]        timeout;
    logic [CNT_W-1:0]   cnt_inc;
    logic [15:0]        timer_inc;

    // Upper CSR bits beyond the sources and the reserved config bits are not used here
    logic unused_bits;
    assign unused_bits = ^{ir_clear[CONFIG_WIDTH-1:NUM_SRC], ir_en[CONFIG_WIDTH-1:NUM_SRC],
                           conf[7:2]};

    // Pending/overflow latching and the derived terms that feed the FSM
    always_comb begin
        clr        = ir_clear[NUM_SRC-1:0];
        en         = ir_en[NUM_SRC-1:0];
        glb_en     = conf[0];
        pulse_mode = conf[1];
        thr_field  = conf[15:8];
        timeout    = conf[31:16];
        thr        = (thr_field[CNT_W-1:0] == '0) ? CNT_W'(1) : thr_field[CNT_W-1:0];

        // An event in the same cycle as its clear wins so nothing is lost
        pending_d  = evt_in | (pending_q & ~clr);
        overflow_d = (overflow_q & ~clr) | (evt_in & pending_q & ~clr);

        masked     = pending_d & en;
        any_masked = |masked;
        newev      = |(evt_in & en);

        cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        timer_inc  = (timer_q == '1) ? timer_q : timer_q + 1'b1;

        status_d                   = '0;
        status_d[NUM_SRC-1:0]      = pending_d;
        status_d[16 +: NUM_SRC]    = overflow_d;
    end

    // Coalescing FSM next-state; the irq line is the registered "entering/staying in FIRE"
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        if (!glb_en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            timer_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_masked) begin
                        cnt_d   = CNT_W'(1);
                        timer_d = '0;
                        state_d = (thr == CNT_W'(1)) ? ST_FIRE : ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (!any_masked) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_inc;
                        cnt_d   = newev ? cnt_inc : cnt_q;
                        if ((cnt_d >= thr) || ((timeout != 16'd0) && (timer_inc >= timeout))) begin
                            state_d = ST_FIRE;
                        end
                    end
                end
                ST_FIRE: begin
                    if (pulse_mode) begin
                        state_d = ST_HOLD;
                    end else if (!any_masked) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        timer_d = '0;
                    end
                end
                ST_HOLD: begin
                    if (!any_masked) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        timer_d = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        irq_d = (state_d == ST_FIRE);
    end

    // All state and outputs registered, cleared asynchronously
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            overflow_q <= '0;
            cnt_q      <= '0;
            timer_q    <= '0;
            irq_q      <= 1'b0;
            status_q   <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
            irq_q      <= irq_d;
            status_q   <= status_d;
        end
    end

    assign status_out = status_q;
    assign irq_out    = irq_q;
    assign irq_state  = state_q;

endmodule
